serial_alu_ctrl: RTL
====================

# serial_alu_ctrl

Bit-serial ALU sequencer. It accepts one WIDTH-bit operation (AND, OR, ADD, SUB) and drives a single 1-bit ALU slice LSB-first, one bit per clock, for WIDTH clocks. Carry is held in a flop between bits, and the result is assembled in a shift register. It sits beside the parallel ALU as the low-area execution path and returns results through a start/done handshake.

## Interface
- WIDTH, 32, operand/result width in bits (legal values ≥ 2)
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- op  input  3  operation: 000 AND, 001 OR, any other code arithmetic; op[2]=1 means subtract
- a  input  WIDTH  operand A, captured when start is accepted
- b  input  WIDTH  operand B, captured when start is accepted
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse when result is valid
- result  output  WIDTH  result; held until the next accepted start
- cout  output  1  final carry for arithmetic (SUB: 1 = no borrow); 0 for logic ops
- ovf  output  1  signed overflow (carry into MSB xor carry out); 0 for logic ops
- zero  output  1  result == 0; valid with done, held with result

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when start=1.
  - Latch a, b and op into shift registers.
  - Clear the bit counter.
  - Preset the carry flop to op[2] for arithmetic codes, 0 for logic codes.
- RUN, every edge:
  - Slice inputs: bit 0 of A shift register, bit 0 of B shift register, carry flop.
  - b-invert = op[2] for arithmetic codes.
  - Slice sum shifts into the MSB of the result register. Operand registers shift right.
  - Carry flop loads the slice carry-out. On logic ops the carry flop is forced to 0.
  - On the last bit, carry-in is captured as the MSB carry for ovf.
  - Counter increments. RUN → DONE after bit WIDTH-1 is processed.
- DONE: done=1 for exactly one cycle. cout, ovf and zero update with result. DONE → IDLE unconditionally.
- start is ignored in RUN and DONE. No queueing.
- Reset:
  - state=IDLE, ready=1, done=0, result=0, cout=0, ovf=0, zero=1.
  - Applies equally mid-operation: the operation is aborted and no done pulse is produced.
- Arithmetic wraps modulo 2^WIDTH. SUB computes a + ~b + 1.

## Timing
- Edge E0 samples start=1 in IDLE. ready=0 from the cycle after E0.
- Bits 0..WIDTH-1 are processed on edges E1..EWIDTH.
- done is high during the cycle after EWIDTH. result, cout, ovf and zero are valid from that same cycle.
- ready=1 again one cycle after done. The next start can be accepted on that edge.
- Throughput: one operation per WIDTH+2 cycles.
- Outputs are registered only. No combinational path from inputs to outputs.

## Structure
- Shared package constants:
  - op encodings OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SUB=3'b110
  - state encoding (IDLE, RUN, DONE)
- Sub-module alu_bit_slice: combinational 1-bit unit.
  - Inputs: a, b, carry_in, b_invert, op.
  - Outputs: sum, cout.
  - Contents: AND/OR/full-adder with XOR-inverted b.
- The controller holds the FSM, bit counter (clog2(WIDTH) bits), operand/result shift registers, carry flop and flag logic.

## Test plan
- WIDTH=8, ADD a=0x7F b=0x01:
  - done 9 cycles after the start edge.
  - result=0x80, cout=0, ovf=1, zero=0.
- WIDTH=8, SUB a=0x05 b=0x07 → result=0xFE, cout=0, ovf=0.
- WIDTH=8, SUB a=0x07 b=0x05 → result=0x02, cout=1.
- WIDTH=8, logic ops on a=0xF0 b=0x3C:
  - AND → 0x30; OR → 0xFC.
  - cout=0, ovf=0 in both cases.
- Handshake:
  - start held high through RUN and DONE → exactly one done pulse per acceptance.
  - A second operation with new a/b is accepted only when ready=1, and result reflects the new operands.
- Reset and wrap:
  - Assert reset at bit 3 of an ADD → next cycle ready=1, result=0, zero=1, and no done pulse.
  - A following WIDTH=32 ADD 0xFFFFFFFF+0x1 → result=0, cout=1, zero=1, ovf=0, done 33 cycles after start.

Source files
------------

// File: rtl/serial_alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_alu_ctrl_pkg
//  Description : Shared op encodings, FSM state type and op decode helper for
//                the bit-serial ALU sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_alu_ctrl_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Every code other than AND/OR is an arithmetic code; op[2] selects subtract.
    function automatic logic is_arith(input logic [2:0] op);
        return (op != OP_AND) && (op != OP_OR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_alu_ctrl_alu_bit_slice.sv
`default_nettype none
// ============================================================================
//  Module      : alu_bit_slice
//  Description : Combinational 1-bit ALU slice: AND, OR, or full adder with
//                XOR-controlled inversion of b. Carry-out is 0 for logic ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_bit_slice
    import serial_alu_ctrl_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic       b_invert,
    input  logic [2:0] op,
    output logic       sum,
    output logic       cout
);

    logic bx;

    assign bx = b ^ b_invert;

    // Select the slice function; arithmetic is a plain full adder on a and bx.
    always_comb begin
        sum  = 1'b0;
        cout = 1'b0;
        if (op == OP_AND) begin
            sum = a & b;
        end else if (op == OP_OR) begin
            sum = a | b;
        end else begin
            sum  = a ^ bx ^ carry_in;
            cout = (a & bx) | (carry_in & (a ^ bx));
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_alu_ctrl
//  Description : Bit-serial ALU sequencer. Captures one WIDTH-bit operation,
//                feeds a single alu_bit_slice LSB-first for WIDTH clocks and
//                returns result/flags through a start/ready/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_ctrl
    import serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int             CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             ready_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic             arith;
    logic             slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] result_d;

    assign arith    = is_arith(op_q);
    // Result register after the current slice bit is shifted into the MSB.
    assign result_d = {slice_sum, result_q[WIDTH-1:1]};

    alu_bit_slice u_slice (
        .a        (a_q[0]),
        .b        (b_q[0]),
        .carry_in (carry_q),
        .b_invert (arith & op_q[2]),
        .op       (op_q),
        .sum      (slice_sum),
        .cout     (slice_cout)
    );

    // Sequencer FSM: capture in IDLE, one bit per edge in RUN, one-cycle DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        cnt_q   <= '0;
                        // Subtract starts with carry=1 to form a + ~b + 1.
                        carry_q <= is_arith(op) & op[2];
                        ready_q <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    result_q <= result_d;
                    carry_q  <= arith & slice_cout;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == C_LAST) begin
                        // carry_q here is the carry into the MSB.
                        cout_q  <= arith & slice_cout;
                        ovf_q   <= arith & (carry_q ^ slice_cout);
                        zero_q  <= (result_d == '0);
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule
`default_nettype wire
